// File: rtl/odometer_pkg.sv
// Shared types and helpers for the beat-frequency odometer measure block.
// Holds the FSM encoding, edge-qualifier modes and a width helper.
package odometer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_COUNT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_BOTH = 2;

  // ceil(log2(n)), never less than 1 so a single channel still gets a select bit
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/odometer_edge_sync.sv
// Per-channel synchroniser for an asynchronous PC_OUT line, with a
// previous-value flop and an EDGE_MODE-selected edge qualifier.
module odometer_edge_sync
  import odometer_pkg::*;
#(
  parameter int EDGE_MODE = EDGE_RISE
) (
  input  logic clk,
  input  logic rst,
  input  logic pc_in,
  output logic edge_o
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q, prev_d;

  always_comb begin
    sync1_d = pc_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  always_comb begin
    edge_o = 1'b0;
    if (EDGE_MODE == EDGE_BOTH) begin
      edge_o = sync2_q ^ prev_q;
    end else if (EDGE_MODE == EDGE_FALL) begin
      edge_o = ~sync2_q & prev_q;
    end else begin
      edge_o = sync2_q & ~prev_q;
    end
  end

endmodule

// File: rtl/odometer_bf_meas_multi.sv
// Beat-frequency period measurement over NCH phase-compare channels:
// channel mux, IDLE/ARM/COUNT/DONE control, saturating accumulator and deadzone timeout.
module odometer_bf_meas_multi
  import odometer_pkg::*;
#(
  parameter int NCH         = 4,
  parameter int CNT_W       = 12,
  parameter int DZ_W        = 13,
  parameter int SKIP_EDGES  = 2,
  parameter int AVG_PERIODS = 1,
  parameter int EDGE_MODE   = 0
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic [NCH-1:0]               PC_OUT,
  input  logic [clog2_min1(NCH)-1:0]   CH_SEL,
  input  logic                         MEAS_TRIG,
  output logic [CNT_W-1:0]             BF_COUNT,
  output logic                         MEAS_DONE,
  output logic                         DEADZONE,
  output logic                         OVERFLOW,
  output logic                         BUSY,
  output logic                         DETECT
);

  localparam int SEL_W = clog2_min1(NCH);

  logic [NCH-1:0]          edge_vec;
  logic [(1<<SEL_W)-1:0]   edge_pad;
  logic                    busy;

  state_e                  state_q, state_d;
  logic [SEL_W-1:0]        ch_q, ch_d;
  logic                    trig_q, trig_d;
  logic                    detect_q, detect_d;
  logic [3:0]              ec_q, ec_d, ec_inc;
  logic [CNT_W-1:0]        acc_q, acc_d, acc_inc;
  logic [CNT_W-1:0]        bf_q, bf_d;
  logic [DZ_W-1:0]         dz_q, dz_d, dz_inc;
  logic                    done_q, done_d;
  logic                    dzflag_q, dzflag_d;
  logic                    ovf_q, ovf_d;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    odometer_edge_sync #(.EDGE_MODE(EDGE_MODE)) u_sync (
      .clk   (CLK),
      .rst   (RESET),
      .pc_in (PC_OUT[gi]),
      .edge_o(edge_vec[gi])
    );
  end

  // Padding keeps the select index in range for non-power-of-two NCH
  always_comb begin
    edge_pad           = '0;
    edge_pad[NCH-1:0]  = edge_vec;
    busy               = (state_q == ST_ARM) || (state_q == ST_COUNT);
    detect_d           = edge_pad[ch_q] & busy;
    trig_d             = MEAS_TRIG;
  end

  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    ec_d     = ec_q;
    acc_d    = acc_q;
    bf_d     = bf_q;
    dz_d     = dz_q;
    dzflag_d = dzflag_q;
    ovf_d    = ovf_q;
    ec_inc   = ec_q + 4'd1;
    acc_inc  = (acc_q == {CNT_W{1'b1}}) ? acc_q : acc_q + CNT_W'(1);
    dz_inc   = dz_q + DZ_W'(1);

    case (state_q)
      ST_IDLE: begin
        if (MEAS_TRIG && !trig_q && (int'(CH_SEL) < NCH)) begin
          ch_d     = CH_SEL;
          ec_d     = '0;
          dz_d     = '0;
          acc_d    = '0;
          ovf_d    = 1'b0;
          dzflag_d = 1'b0;
          state_d  = ST_ARM;
        end
      end
      ST_ARM: begin
        dz_d = dz_inc;
        if (detect_q) begin
          dz_d = '0;
          if (ec_inc == 4'(SKIP_EDGES)) begin
            ec_d    = '0;
            acc_d   = '0;
            state_d = ST_COUNT;
          end else begin
            ec_d = ec_inc;
          end
        end else if (dz_q == {DZ_W{1'b1}}) begin
          bf_d     = {CNT_W{1'b1}};
          dzflag_d = 1'b1;
          state_d  = ST_DONE;
        end
      end
      ST_COUNT: begin
        acc_d = acc_inc;
        if (acc_inc == {CNT_W{1'b1}}) ovf_d = 1'b1;
        dz_d = dz_inc;
        // An edge arriving together with the timeout takes precedence
        if (detect_q) begin
          dz_d = '0;
          if (ec_inc == 4'(AVG_PERIODS)) begin
            bf_d    = acc_inc;
            state_d = ST_DONE;
          end else begin
            ec_d = ec_inc;
          end
        end else if (dz_q == {DZ_W{1'b1}}) begin
          bf_d     = {CNT_W{1'b1}};
          dzflag_d = 1'b1;
          state_d  = ST_DONE;
        end
      end
      default: ;
    endcase

    // Dropping MEAS_TRIG overrides any completion decided above
    if (!MEAS_TRIG) begin
      state_d  = ST_IDLE;
      bf_d     = bf_q;
      dzflag_d = 1'b0;
      ovf_d    = 1'b0;
    end

    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      ch_q     <= '0;
      trig_q   <= 1'b0;
      detect_q <= 1'b0;
      ec_q     <= '0;
      acc_q    <= '0;
      bf_q     <= '0;
      dz_q     <= '0;
      done_q   <= 1'b0;
      dzflag_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      trig_q   <= trig_d;
      detect_q <= detect_d;
      ec_q     <= ec_d;
      acc_q    <= acc_d;
      bf_q     <= bf_d;
      dz_q     <= dz_d;
      done_q   <= done_d;
      dzflag_q <= dzflag_d;
      ovf_q    <= ovf_d;
    end
  end

  assign BF_COUNT  = bf_q;
  assign MEAS_DONE = done_q;
  assign DEADZONE  = dzflag_q;
  assign OVERFLOW  = ovf_q;
  assign BUSY      = busy;
  assign DETECT    = detect_q;

endmodule

// File: tb/tb_odometer_bf_meas_multi.sv
// Directed bench for the odometer measure block: a default instance, an averaging
// instance with three channels, and a both-edges instance share one stimulus.
module tb_odometer_bf_meas_multi;

  logic        clk;
  logic        reset;
  logic [3:0]  pc_out;
  logic [1:0]  ch_sel;
  logic        meas_trig;

  logic [11:0] bf0, bf1, bf2;
  logic        done0, dz0, ovf0, busy0, det0;
  logic        done1, dz1, ovf1, busy1, det1;
  logic        done2, dz2, ovf2, busy2, det2;

  int n_checks;
  int n_fail;
  int det_count;
  int wait_n;

  odometer_bf_meas_multi u_dut (
    .CLK(clk), .RESET(reset), .PC_OUT(pc_out), .CH_SEL(ch_sel), .MEAS_TRIG(meas_trig),
    .BF_COUNT(bf0), .MEAS_DONE(done0), .DEADZONE(dz0), .OVERFLOW(ovf0),
    .BUSY(busy0), .DETECT(det0)
  );

  odometer_bf_meas_multi #(.NCH(3), .AVG_PERIODS(4)) u_avg (
    .CLK(clk), .RESET(reset), .PC_OUT(pc_out[2:0]), .CH_SEL(ch_sel), .MEAS_TRIG(meas_trig),
    .BF_COUNT(bf1), .MEAS_DONE(done1), .DEADZONE(dz1), .OVERFLOW(ovf1),
    .BUSY(busy1), .DETECT(det1)
  );

  odometer_bf_meas_multi #(.EDGE_MODE(2)) u_both (
    .CLK(clk), .RESET(reset), .PC_OUT(pc_out), .CH_SEL(ch_sel), .MEAS_TRIG(meas_trig),
    .BF_COUNT(bf2), .MEAS_DONE(done2), .DEADZONE(dz2), .OVERFLOW(ovf2),
    .BUSY(busy2), .DETECT(det2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, actual, actual, expected, expected);
    end
  endtask

  // Advance on falling edges, tallying DETECT pulses of the default instance
  task automatic waitCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (det0) det_count++;
    end
  endtask

  // Square wave on one channel, rising edges exactly 'period' cycles apart
  task automatic applyStimulus(input int chan, input int period, input int n_edges);
    for (int e = 0; e < n_edges; e++) begin
      pc_out[chan] = 1'b1;
      waitCycles(period / 2);
      pc_out[chan] = 1'b0;
      waitCycles(period - period / 2);
    end
  endtask

  task automatic retrigger(input logic [1:0] ch);
    meas_trig = 1'b0;
    waitCycles(2);
    ch_sel    = ch;
    meas_trig = 1'b1;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    det_count = 0;
    reset     = 1'b1;
    pc_out    = 4'b0;
    ch_sel    = 2'd0;
    meas_trig = 1'b0;
    waitCycles(3);
    reset = 1'b0;
    waitCycles(2);

    $display("[TB] reset state");
    checkOutput("reset_bf", 32'(bf0), 32'd0);
    checkOutput("reset_done", 32'(done0), 32'd0);
    checkOutput("reset_dz", 32'(dz0), 32'd0);
    checkOutput("reset_ovf", 32'(ovf0), 32'd0);
    checkOutput("reset_busy", 32'(busy0), 32'd0);
    checkOutput("reset_detect", 32'(det0), 32'd0);

    $display("[TB] single period, rising edges 100 apart");
    retrigger(2'd2);
    waitCycles(2);
    checkOutput("t1_busy_arm", 32'(busy0), 32'd1);
    det_count = 0;
    applyStimulus(2, 100, 3);
    checkOutput("t1_bf", 32'(bf0), 32'd100);
    checkOutput("t1_done", 32'(done0), 32'd1);
    checkOutput("t1_dz", 32'(dz0), 32'd0);
    checkOutput("t1_ovf", 32'(ovf0), 32'd0);
    checkOutput("t1_busy_done", 32'(busy0), 32'd0);
    checkOutput("t1_detect_cnt", 32'(det_count), 32'd3);
    meas_trig = 1'b0;
    waitCycles(2);
    checkOutput("t1_done_clear", 32'(done0), 32'd0);
    checkOutput("t1_bf_kept", 32'(bf0), 32'd100);

    $display("[TB] averaging over 4 periods of 250");
    retrigger(2'd2);
    applyStimulus(2, 250, 6);
    checkOutput("t2_avg_bf", 32'(bf1), 32'd1000);
    checkOutput("t2_avg_done", 32'(done1), 32'd1);
    checkOutput("t2_dflt_bf", 32'(bf0), 32'd250);
    checkOutput("t2_both_bf", 32'(bf2), 32'd125);

    $display("[TB] both edges, 50%% duty, period 100");
    retrigger(2'd2);
    applyStimulus(2, 100, 3);
    checkOutput("t2b_both_bf", 32'(bf2), 32'd50);
    checkOutput("t2b_both_done", 32'(done2), 32'd1);

    $display("[TB] deadzone timeout");
    retrigger(2'd2);
    wait_n = 0;
    while (!done0 && wait_n < 9000) begin
      waitCycles(1);
      wait_n++;
    end
    checkOutput("t3_wait_cycles", 32'(wait_n), 32'd8193);
    checkOutput("t3_bf", 32'(bf0), 32'hFFF);
    checkOutput("t3_dz", 32'(dz0), 32'd1);
    checkOutput("t3_done", 32'(done0), 32'd1);
    checkOutput("t3_ovf", 32'(ovf0), 32'd0);
    meas_trig = 1'b0;
    waitCycles(2);
    checkOutput("t3_dz_clear", 32'(dz0), 32'd0);

    $display("[TB] accumulator overflow, period 5000");
    retrigger(2'd2);
    applyStimulus(2, 5000, 3);
    checkOutput("t4_ovf", 32'(ovf0), 32'd1);
    checkOutput("t4_bf", 32'(bf0), 32'hFFF);
    checkOutput("t4_dz", 32'(dz0), 32'd0);
    checkOutput("t4_done", 32'(done0), 32'd1);
    meas_trig = 1'b0;
    waitCycles(2);
    checkOutput("t4_ovf_clear", 32'(ovf0), 32'd0);

    $display("[TB] abort during COUNT");
    retrigger(2'd2);
    applyStimulus(2, 100, 2);
    checkOutput("t5_busy_count", 32'(busy0), 32'd1);
    meas_trig = 1'b0;
    waitCycles(1);
    checkOutput("t5_busy_abort", 32'(busy0), 32'd0);
    checkOutput("t5_done_abort", 32'(done0), 32'd0);
    applyStimulus(2, 100, 2);
    checkOutput("t5_done_stays", 32'(done0), 32'd0);

    $display("[TB] unselected channels");
    retrigger(2'd1);
    waitCycles(2);
    det_count = 0;
    applyStimulus(0, 40, 3);
    applyStimulus(3, 40, 3);
    checkOutput("t5_unsel_detect", 32'(det_count), 32'd0);
    checkOutput("t5_unsel_busy", 32'(busy0), 32'd1);

    $display("[TB] reset during ARM");
    reset = 1'b1;
    #1;
    checkOutput("t6_rst_busy", 32'(busy0), 32'd0);
    checkOutput("t6_rst_bf", 32'(bf0), 32'd0);
    checkOutput("t6_rst_done", 32'(done0), 32'd0);
    waitCycles(1);
    reset = 1'b0;
    waitCycles(1);

    $display("[TB] out-of-range channel select");
    retrigger(2'd3);
    waitCycles(5);
    checkOutput("t6_ignore_busy", 32'(busy1), 32'd0);
    checkOutput("t6_valid_busy", 32'(busy0), 32'd1);
    ch_sel    = 2'd2;
    det_count = 0;
    applyStimulus(2, 40, 3);
    checkOutput("t6_chsel_latched", 32'(det_count), 32'd0);
    meas_trig = 1'b0;
    waitCycles(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
